// File: rtl/ram_rsv_station_pkg.sv
// Shared reservation-station types and flag bit positions (package cpu_pkg).
// Entry field widths are fixed here; ram_rsv_station checks its parameters against them.
package cpu_pkg;

  localparam int unsigned RSV_DATA_W  = 8;
  localparam int unsigned RSV_ROBID_W = 4;

  localparam int unsigned FLAG_WRITE_EN = 1;
  localparam int unsigned FLAG_NO_CDB   = 7;

  typedef struct packed {
    logic                   rdy;
    logic [RSV_ROBID_W-1:0] tag;
    logic [RSV_DATA_W-1:0]  val;
  } rsv_src_t;

  typedef struct packed {
    logic                   valid;
    logic [7:0]             operand;
    logic [7:0]             flags;
    logic [7:0]             wbs;
    logic [RSV_ROBID_W-1:0] robid;
    rsv_src_t [1:0]         src;
  } rsv_entry_t;

  function automatic logic entry_ready(input rsv_entry_t e);
    return e.valid && e.src[0].rdy && e.src[1].rdy;
  endfunction

endpackage

// File: rtl/ram_rsv_station_snoop.sv
// Single-source CDB snoop: a pending source whose tag matches the broadcast
// captures the broadcast value and becomes ready.
module rsv_src_snoop
  import cpu_pkg::*;
(
  input  logic                   cdb_valid,
  input  logic [RSV_ROBID_W-1:0] cdb_id,
  input  logic [RSV_DATA_W-1:0]  cdb_val,
  input  rsv_src_t               src_i,
  output rsv_src_t               src_o
);

  always_comb begin
    src_o = src_i;
    if (cdb_valid && !src_i.rdy && (src_i.tag == cdb_id)) begin
      src_o.rdy = 1'b1;
      src_o.val = cdb_val;
    end
  end

endmodule

// File: rtl/ram_rsv_station.sv
// In-order reservation station for the RAM functional unit.
// Optional perf counters (stall_busy_cnt, stall_dep_cnt) enabled by RAM_RSV_PERF_EN.
module ram_rsv_station
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROBID_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [7:0]                     disp_operand,
  input  logic [7:0]                     disp_flags,
  input  logic [7:0]                     disp_wbs,
  input  logic [ROBID_W-1:0]             disp_robid,
  input  logic [1:0]                     disp_src_rdy,
  input  logic [1:0][ROBID_W-1:0]        disp_src_tag,
  input  logic [1:0][DATA_W-1:0]         disp_src_val,
  input  logic                           cdb_valid,
  input  logic [ROBID_W-1:0]             cdb_id,
  input  logic [DATA_W-1:0]              cdb_val,
  input  logic                           fu_busy,
  input  logic                           flush,
  output logic                           input_transmit,
  output logic [7:0]                     operand,
  output logic [1:0][DATA_W-1:0]         depvals,
  output logic [7:0]                     wbs,
  output logic [7:0]                     flags,
  output logic [ROBID_W-1:0]             robid,
`ifdef RAM_RSV_PERF_EN
  output logic [15:0]                    stall_busy_cnt,
  output logic [15:0]                    stall_dep_cnt,
`endif
  output logic [$clog2(DEPTH):0]         count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ram_rsv_station: DEPTH must be a power of two >= 2");
  end
  if ((DATA_W != RSV_DATA_W) || (ROBID_W != RSV_ROBID_W)) begin : g_bad_width
    $error("ram_rsv_station: DATA_W/ROBID_W must match cpu_pkg entry widths");
  end

  rsv_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   xmit_q, xmit_d;
  logic [7:0]             operand_q, operand_d, wbs_q, wbs_d, flags_q, flags_d;
  logic [1:0][DATA_W-1:0] depvals_q, depvals_d;
  logic [ROBID_W-1:0]     robid_q, robid_d;

  rsv_src_t snp_src [DEPTH][2];
  rsv_src_t disp_raw [2];
  rsv_src_t byp_src [2];

  logic head_ready, do_issue, do_disp;

  for (genvar s = 0; s < 2; s++) begin : g_disp_src
    assign disp_raw[s] = '{rdy: disp_src_rdy[s], tag: disp_src_tag[s], val: disp_src_val[s]};
    rsv_src_snoop u_byp (
      .cdb_valid (cdb_valid),
      .cdb_id    (cdb_id),
      .cdb_val   (cdb_val),
      .src_i     (disp_raw[s]),
      .src_o     (byp_src[s])
    );
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    for (genvar s = 0; s < 2; s++) begin : g_src
      rsv_src_snoop u_snp (
        .cdb_valid (cdb_valid),
        .cdb_id    (cdb_id),
        .cdb_val   (cdb_val),
        .src_i     (ent_q[e].src[s]),
        .src_o     (snp_src[e][s])
      );
    end
  end

  assign disp_ready = (count_q != CNT_W'(DEPTH));
  // Issue readiness uses registered rdy bits, so a CDB capture issues one cycle later.
  assign head_ready = entry_ready(ent_q[head_q]);
  assign do_issue   = head_ready && !fu_busy && !flush;
  assign do_disp    = disp_valid && disp_ready && !flush;

  always_comb begin
    ent_d     = ent_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    xmit_d    = 1'b0;
    operand_d = operand_q;
    depvals_d = depvals_q;
    wbs_d     = wbs_q;
    flags_d   = flags_q;
    robid_d   = robid_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned s = 0; s < 2; s++) begin
        ent_d[i].src[s] = snp_src[i][s];
      end
    end

    if (do_issue) begin
      xmit_d       = 1'b1;
      operand_d    = ent_q[head_q].operand;
      wbs_d        = ent_q[head_q].wbs;
      flags_d      = ent_q[head_q].flags;
      robid_d      = ent_q[head_q].robid;
      depvals_d[0] = ent_q[head_q].src[0].val;
      depvals_d[1] = ent_q[head_q].src[1].val;
      ent_d[head_q].valid = 1'b0;
      head_d       = head_q + PTR_W'(1);
    end

    // Tail never aliases an issuing head: that would require a full queue, which blocks dispatch.
    if (do_disp) begin
      ent_d[tail_q].valid   = 1'b1;
      ent_d[tail_q].operand = disp_operand;
      ent_d[tail_q].flags   = disp_flags;
      ent_d[tail_q].wbs     = disp_wbs;
      ent_d[tail_q].robid   = disp_robid;
      ent_d[tail_q].src[0]  = byp_src[0];
      ent_d[tail_q].src[1]  = byp_src[1];
      tail_d                = tail_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(do_disp) - CNT_W'(do_issue);

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      xmit_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      xmit_q    <= 1'b0;
      operand_q <= '0;
      depvals_q <= '0;
      wbs_q     <= '0;
      flags_q   <= '0;
      robid_q   <= '0;
    end else begin
      ent_q     <= ent_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      xmit_q    <= xmit_d;
      operand_q <= operand_d;
      depvals_q <= depvals_d;
      wbs_q     <= wbs_d;
      flags_q   <= flags_d;
      robid_q   <= robid_d;
    end
  end

  assign count          = count_q;
  assign input_transmit = xmit_q;
  assign operand        = operand_q;
  assign depvals        = depvals_q;
  assign wbs            = wbs_q;
  assign flags          = flags_q;
  assign robid          = robid_q;

`ifdef RAM_RSV_PERF_EN
  logic [15:0] stall_busy_q, stall_busy_d, stall_dep_q, stall_dep_d;

  always_comb begin
    stall_busy_d = stall_busy_q;
    stall_dep_d  = stall_dep_q;
    if (head_ready && fu_busy && !(&stall_busy_q)) begin
      stall_busy_d = stall_busy_q + 16'd1;
    end
    if (ent_q[head_q].valid && !head_ready && !(&stall_dep_q)) begin
      stall_dep_d = stall_dep_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_busy_q <= '0;
      stall_dep_q  <= '0;
    end else begin
      stall_busy_q <= stall_busy_d;
      stall_dep_q  <= stall_dep_d;
    end
  end

  assign stall_busy_cnt = stall_busy_q;
  assign stall_dep_cnt  = stall_dep_q;
`endif

endmodule

// File: tb/tb_ram_rsv_station.sv
// Self-checking bench for ram_rsv_station: directed scenarios plus random traffic
// against a queue-based reference model. Perf counters checked when RAM_RSV_PERF_EN is set.
module tb_ram_rsv_station;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst, disp_valid, disp_ready;
  logic [7:0]      disp_operand, disp_flags, disp_wbs;
  logic [3:0]      disp_robid;
  logic [1:0]      disp_src_rdy;
  logic [1:0][3:0] disp_src_tag;
  logic [1:0][7:0] disp_src_val;
  logic            cdb_valid;
  logic [3:0]      cdb_id;
  logic [7:0]      cdb_val;
  logic            fu_busy, flush, input_transmit;
  logic [7:0]      operand, wbs, flags;
  logic [1:0][7:0] depvals;
  logic [3:0]      robid;
  logic [2:0]      count;
`ifdef RAM_RSV_PERF_EN
  logic [15:0]     stall_busy_cnt, stall_dep_cnt;
`endif

  ram_rsv_station #(.DEPTH(DEPTH), .DATA_W(8), .ROBID_W(4)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_operand(disp_operand), .disp_flags(disp_flags), .disp_wbs(disp_wbs),
    .disp_robid(disp_robid), .disp_src_rdy(disp_src_rdy), .disp_src_tag(disp_src_tag),
    .disp_src_val(disp_src_val), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .fu_busy(fu_busy), .flush(flush), .input_transmit(input_transmit), .operand(operand),
    .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid),
`ifdef RAM_RSV_PERF_EN
    .stall_busy_cnt(stall_busy_cnt), .stall_dep_cnt(stall_dep_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      operand, flags, wbs;
    logic [3:0]      robid;
    logic [1:0]      rdy;
    logic [1:0][3:0] tag;
    logic [1:0][7:0] val;
  } op_t;

  op_t        mq[$];
  op_t        m_out;
  logic       m_xmit;
  int         m_busy, m_dep;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a FIFO of ops; the head leaves when both sources are known and the FU is free.
  task automatic model_step();
    op_t n;
    bit  issue, hrdy;
    if (rst) begin
      mq.delete();
      m_out  = '0;
      m_xmit = 1'b0;
      m_busy = 0;
      m_dep  = 0;
      return;
    end
    hrdy = (mq.size() > 0) && (mq[0].rdy == 2'b11);
    if (hrdy && fu_busy) m_busy++;
    if ((mq.size() > 0) && !hrdy) m_dep++;
    if (flush) begin
      mq.delete();
      m_xmit = 1'b0;
      return;
    end
    issue = hrdy && !fu_busy;
    m_xmit = issue;
    if (issue) m_out = mq.pop_front();
    if (cdb_valid) begin
      foreach (mq[i]) begin
        for (int s = 0; s < 2; s++) begin
          if (!mq[i].rdy[s] && mq[i].tag[s] == cdb_id) begin
            mq[i].rdy[s] = 1'b1;
            mq[i].val[s] = cdb_val;
          end
        end
      end
    end
    // Dispatch acceptance looks at occupancy before this cycle's issue.
    if (disp_valid && (mq.size() + (issue ? 1 : 0)) != DEPTH) begin
      n.operand = disp_operand; n.flags = disp_flags; n.wbs = disp_wbs; n.robid = disp_robid;
      n.rdy = disp_src_rdy; n.tag = disp_src_tag; n.val = disp_src_val;
      for (int s = 0; s < 2; s++) begin
        if (!n.rdy[s] && cdb_valid && n.tag[s] == cdb_id) begin
          n.rdy[s] = 1'b1;
          n.val[s] = cdb_val;
        end
      end
      mq.push_back(n);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(mq.size()));
    check("disp_ready", 32'(disp_ready), 32'(mq.size() != DEPTH));
    check("xmit", 32'(input_transmit), 32'(m_xmit));
    check("operand", 32'(operand), 32'(m_out.operand));
    check("depvals", 32'(depvals), 32'(m_out.val));
    check("wbs", 32'(wbs), 32'(m_out.wbs));
    check("flags", 32'(flags), 32'(m_out.flags));
    check("robid", 32'(robid), 32'(m_out.robid));
`ifdef RAM_RSV_PERF_EN
    check("stall_busy", 32'(stall_busy_cnt), 32'(m_busy));
    check("stall_dep", 32'(stall_dep_cnt), 32'(m_dep));
`endif
  endtask

  task automatic idle();
    rst = 0; flush = 0; disp_valid = 0; cdb_valid = 0; cdb_id = 0; cdb_val = 0;
    disp_operand = 0; disp_flags = 0; disp_wbs = 0; disp_robid = 0;
    disp_src_rdy = 0; disp_src_tag = 0; disp_src_val = 0;
  endtask

  task automatic set_disp(input logic [3:0] rid, input logic [1:0] rdy,
                          input logic [3:0] tag1, input logic [7:0] val1, input logic [7:0] val0);
    disp_valid      = 1'b1;
    disp_robid      = rid;
    disp_operand    = 8'h40 + 8'(rid);
    disp_flags      = 8'h02;
    disp_wbs        = 8'h10 + 8'(rid);
    disp_src_rdy    = rdy;
    disp_src_tag[1] = tag1;
    disp_src_tag[0] = 4'hF;
    disp_src_val[1] = val1;
    disp_src_val[0] = val0;
  endtask

  initial begin
    idle();
    fu_busy = 0;
    rst = 1;
    step(); step();
    check("rst_ready", 32'(disp_ready), 32'd1);
    check("rst_xmit", 32'(input_transmit), 32'd0);
    rst = 0;

    // ready load: issue visible one edge after the dispatch edge
    set_disp(4'd3, 2'b11, 4'd0, 8'h10, 8'h33);
    step();
    disp_valid = 0;
    check("lat_early", 32'(input_transmit), 32'd0);
    step();
    check("lat_xmit", 32'(input_transmit), 32'd1);
    check("lat_dep1", 32'(depvals[1]), 32'h10);
    check("lat_robid", 32'(robid), 32'd3);
    step();

    // store waits on tag 5
    set_disp(4'd4, 2'b01, 4'd5, 8'h00, 8'h77);
    step();
    disp_valid = 0;
    step();
    cdb_valid = 1; cdb_id = 4'd5; cdb_val = 8'h22;
    step();
    check("cdb_noissue", 32'(input_transmit), 32'd0);
    cdb_valid = 0;
    step();
    check("cdb_xmit", 32'(input_transmit), 32'd1);
    check("cdb_dep1", 32'(depvals[1]), 32'h22);

    // fill while FU busy, then drain in order and refill across the wrap
    fu_busy = 1;
    for (int i = 0; i < 5; i++) begin
      set_disp(4'(8 + i), 2'b11, 4'd0, 8'(i), 8'(i + 1));
      step();
    end
    disp_valid = 0;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(disp_ready), 32'd0);
    fu_busy = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_robid", 32'(robid), 32'(8 + i));
    end
    for (int i = 0; i < 3; i++) begin
      set_disp(4'(1 + i), 2'b11, 4'd0, 8'(i + 8'h50), 8'h00);
      step();
    end
    disp_valid = 0;
    step(); step();

    // same-cycle bypass of tag 7
    set_disp(4'd6, 2'b01, 4'd7, 8'h00, 8'h01);
    cdb_valid = 1; cdb_id = 4'd7; cdb_val = 8'hA5;
    step();
    idle();
    step();
    check("byp_xmit", 32'(input_transmit), 32'd1);
    check("byp_dep1", 32'(depvals[1]), 32'hA5);

    // flush with concurrent dispatch
    fu_busy = 1;
    for (int i = 0; i < 3; i++) begin
      set_disp(4'(i), 2'b11, 4'd0, 8'h01, 8'h02);
      step();
    end
    flush = 1;
    step();
    check("flush_count", 32'(count), 32'd0);
    check("flush_ready", 32'(disp_ready), 32'd1);
    idle();
    fu_busy = 0;
    step();
    check("flush_xmit", 32'(input_transmit), 32'd0);

    // reset with a pending issue
    set_disp(4'd9, 2'b11, 4'd0, 8'h11, 8'h22);
    step();
    idle();
    rst = 1;
    step();
    check("rst_mid_xmit", 32'(input_transmit), 32'd0);
    rst = 0;

`ifdef RAM_RSV_PERF_EN
    fu_busy = 1;
    set_disp(4'd1, 2'b11, 4'd0, 8'h01, 8'h02);
    step();
    idle();
    step(); step(); step();
    fu_busy = 0;
    step();
    set_disp(4'd2, 2'b01, 4'd9, 8'h00, 8'h02);
    step();
    idle();
    step(); step();
    check("perf_busy", 32'(stall_busy_cnt), 32'd3);
    check("perf_dep", 32'(stall_dep_cnt), 32'd2);
    cdb_valid = 1; cdb_id = 4'd9; cdb_val = 8'h99;
    step();
    idle();
    step();
`endif

    // random traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 49) == 0);
      fu_busy = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 1) == 1) begin
        set_disp(4'($urandom), 2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
        disp_src_tag[0] = 4'($urandom);
        disp_flags      = 8'($urandom);
      end
      cdb_valid = ($urandom_range(0, 9) < 5);
      cdb_id    = 4'($urandom);
      cdb_val   = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
